decoder_32: RTL and testbench
=============================

Name: decoder_32

Overview:
- Registered MIPS-I instruction decoder for the single-cycle/pipelined MIPS core.
- Splits a 32-bit instruction word into R/I/J fields and produces immediate extensions, format class and a small set of control flags.
- Sits between instruction fetch and the register file / ALU control.
- One-cycle latency; all outputs come from flops.

Parameters:
- none (fixed 32-bit MIPS encoding; field widths are constants in the shared package)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction word is valid this cycle
- instruction  in  32  raw instruction word
- out_valid  out  1  decoded outputs valid (instr_valid delayed 1 cycle)
- opcode  out  6  instruction[31:26]
- rs  out  5  instruction[25:21]
- rt  out  5  instruction[20:16]
- rd  out  5  instruction[15:11]
- shamt  out  5  instruction[10:6]
- funct  out  6  instruction[5:0]
- immediate  out  16  instruction[15:0]
- jump_target  out  26  instruction[25:0]
- imm_sext  out  32  immediate sign-extended
- imm_zext  out  32  immediate zero-extended
- is_rtype  out  1  opcode==0x00
- is_jtype  out  1  opcode 0x02 (j) or 0x03 (jal)
- is_itype  out  1  neither R nor J
- is_load  out  1  opcode in {0x20,0x21,0x23,0x24,0x25}
- is_store  out  1  opcode in {0x28,0x29,0x2B}
- is_branch  out  1  opcode in {0x01,0x04,0x05,0x06,0x07}
- is_jump  out  1  j, jal, or R-type funct 0x08 (jr) / 0x09 (jalr)
- reg_write  out  1  instruction writes a GPR
- dest_reg  out  5  GPR written; 0 when reg_write=0

Behaviour:
- Reset (rst=1 at clk edge): every output register cleared to 0, out_valid=0. rst has priority over instr_valid.
- Capture: on a clk edge with rst=0 and instr_valid=1, all field and flag registers load values decoded from instruction.
- Latency: outputs visible the cycle after capture; out_valid<=instr_valid every non-reset cycle.
- instr_valid=0: field and flag registers hold their previous values; out_valid drops to 0.
- Field extraction is pure bit slicing and is independent of format. All fields are always driven, e.g. rd/shamt/funct for an I-type word.
- imm_sext = {16{instruction[15]}, instruction[15:0]}.
- imm_zext = {16'h0, instruction[15:0]}.
- Exactly one of is_rtype/is_itype/is_jtype is 1 whenever out_valid=1. After reset all three are 0.
- reg_write/dest_reg rules:
  - R-type except jr: write, dest=rd.
  - jr: reg_write=0.
  - jal: write, dest=31.
  - opcode 0x01 with rt in {0x10,0x11} (bltzal/bgezal): write, dest=31.
  - loads and I-type ALU ops (opcode 0x08–0x0F): write, dest=rt.
  - stores, other branches, j, and unrecognised opcodes: reg_write=0, dest=0.
- reg_write is forced 0 when the computed dest is 0. Writes to $zero are suppressed.
- Unknown opcodes:
  - classified is_itype.
  - all control flags 0; no error output.
- No combinational path from input to output.

Decomposition:
- Shared package mips_pkg:
  - field bit-position constants.
  - opcode localparams (OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI…OP_LUI, OP_LB…OP_LHU, OP_SB, OP_SH, OP_SW).
  - funct localparams (FN_JR, FN_JALR, FN_ADD, FN_SLT).
  - REG_RA=31.
- One natural sub-module: decoder_32_ctrl. Combinational opcode/funct/rt → class and control flags, dest_reg. decoder_32 wraps it plus field slicing and the output register stage.

Test Plan:
- Reset then 32'hFFFFFFFF with instr_valid=1 → next cycle:
  - opcode=63, rs=rt=rd=shamt=31, funct=63.
  - immediate=FFFF, jump_target=3FFFFFF, imm_sext=FFFFFFFF, imm_zext=0000FFFF.
  - is_itype=1, reg_write=0, out_valid=1.
- 32'h01295020 (add $10,$9,$9) → opcode 0, rs 9, rt 9, rd 10, shamt 0, funct 0x20, is_rtype=1, reg_write=1, dest_reg=10; 32'h016C402A → rs 11, rt 12, rd 8, funct 0x2A, dest 8.
- I-type sequence:
  - 32'h20090003 → opcode 8, rs 0, rt 9, immediate 0003, dest 9.
  - 32'hAE090000 → opcode 0x2B, rs 16, rt 9, is_store=1, reg_write=0.
  - 32'h8E0B0000 → opcode 0x23, is_load=1, dest 11.
- Immediate extension: {6'h01,5'h01,5'h01,16'h8000} → imm_sext=FFFF8000, imm_zext=00008000, is_branch=1; with 16'h0000 → both 0.
- Jumps:
  - {6'h03,26'h3FFFFFF} → is_jtype=1, is_jump=1, dest 31, jump_target=3FFFFFF.
  - {6'h02,26'h2000000} → jump_target=2000000, reg_write=0.
  - 32'h03E00008 (jr $31) → is_jump=1, reg_write=0.
- Control:
  - instr_valid=0 for 2 cycles → out_valid=0, fields hold last value.
  - rst asserted concurrently with instr_valid=1 → all outputs 0 next cycle.
  - 32'h00000020 (add $0) → reg_write=0, dest_reg=0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS-I field positions, opcode/funct codes and register constants
package mips_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int TARGET_MSB = 25;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;
    localparam logic [4:0] REG_RA    = 5'd31;

endpackage

// File: rtl/decoder_32_ctrl.sv
// rtl/decoder_32_ctrl.sv - combinational format class, control flags and GPR destination
module decoder_32_ctrl
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic [5:0] funct,
    output logic       is_rtype,
    output logic       is_itype,
    output logic       is_jtype,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       reg_write,
    output logic [4:0] dest_reg
);

    logic       write_req;
    logic [4:0] dest_req;

    always_comb begin
        is_rtype  = 1'b0;
        is_itype  = 1'b0;
        is_jtype  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        write_req = 1'b0;
        dest_req  = 5'd0;
        unique case (opcode)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                if (funct == FN_JR) begin
                    is_jump = 1'b1;
                end else begin
                    write_req = 1'b1;
                    dest_req  = rd;
                    is_jump   = (funct == FN_JALR);
                end
            end
            OP_REGIMM: begin
                is_itype  = 1'b1;
                is_branch = 1'b1;
                // bltzal/bgezal link into $ra even though they are I-format
                if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
                    write_req = 1'b1;
                    dest_req  = REG_RA;
                end
            end
            OP_J: begin
                is_jtype = 1'b1;
                is_jump  = 1'b1;
            end
            OP_JAL: begin
                is_jtype  = 1'b1;
                is_jump   = 1'b1;
                write_req = 1'b1;
                dest_req  = REG_RA;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                is_itype  = 1'b1;
                is_branch = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                is_itype  = 1'b1;
                write_req = 1'b1;
                dest_req  = rt;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                is_itype  = 1'b1;
                is_load   = 1'b1;
                write_req = 1'b1;
                dest_req  = rt;
            end
            OP_SB, OP_SH, OP_SW: begin
                is_itype = 1'b1;
                is_store = 1'b1;
            end
            default: begin
                is_itype = 1'b1;
            end
        endcase
        // writes to $zero are dropped so downstream never sees a $0 write
        reg_write = write_req && (dest_req != 5'd0);
        dest_reg  = reg_write ? dest_req : 5'd0;
    end

endmodule

// File: rtl/decoder_32.sv
// rtl/decoder_32.sv - registered MIPS-I instruction decoder, one cycle latency
module decoder_32
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic        out_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] jump_target,
    output logic [31:0] imm_sext,
    output logic [31:0] imm_zext,
    output logic        is_rtype,
    output logic        is_jtype,
    output logic        is_itype,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jump,
    output logic        reg_write,
    output logic [4:0]  dest_reg
);

    logic [5:0]  f_opcode;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  f_shamt;
    logic [5:0]  f_funct;
    logic [15:0] f_imm;
    logic [25:0] f_target;

    assign f_opcode = instruction[OPCODE_MSB:OPCODE_LSB];
    assign f_rs     = instruction[RS_MSB:RS_LSB];
    assign f_rt     = instruction[RT_MSB:RT_LSB];
    assign f_rd     = instruction[RD_MSB:RD_LSB];
    assign f_shamt  = instruction[SHAMT_MSB:SHAMT_LSB];
    assign f_funct  = instruction[FUNCT_MSB:FUNCT_LSB];
    assign f_imm    = instruction[IMM_MSB:0];
    assign f_target = instruction[TARGET_MSB:0];

    logic       c_rtype;
    logic       c_itype;
    logic       c_jtype;
    logic       c_load;
    logic       c_store;
    logic       c_branch;
    logic       c_jump;
    logic       c_reg_write;
    logic [4:0] c_dest;

    decoder_32_ctrl u_ctrl (
        .opcode    (f_opcode),
        .rt        (f_rt),
        .rd        (f_rd),
        .funct     (f_funct),
        .is_rtype  (c_rtype),
        .is_itype  (c_itype),
        .is_jtype  (c_jtype),
        .is_load   (c_load),
        .is_store  (c_store),
        .is_branch (c_branch),
        .is_jump   (c_jump),
        .reg_write (c_reg_write),
        .dest_reg  (c_dest)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            opcode      <= '0;
            rs          <= '0;
            rt          <= '0;
            rd          <= '0;
            shamt       <= '0;
            funct       <= '0;
            immediate   <= '0;
            jump_target <= '0;
            imm_sext    <= '0;
            imm_zext    <= '0;
            is_rtype    <= 1'b0;
            is_jtype    <= 1'b0;
            is_itype    <= 1'b0;
            is_load     <= 1'b0;
            is_store    <= 1'b0;
            is_branch   <= 1'b0;
            is_jump     <= 1'b0;
            reg_write   <= 1'b0;
            dest_reg    <= '0;
        end else begin
            out_valid <= instr_valid;
            // decoded registers hold across bubbles; only out_valid tracks them
            if (instr_valid) begin
                opcode      <= f_opcode;
                rs          <= f_rs;
                rt          <= f_rt;
                rd          <= f_rd;
                shamt       <= f_shamt;
                funct       <= f_funct;
                immediate   <= f_imm;
                jump_target <= f_target;
                imm_sext    <= {{16{f_imm[15]}}, f_imm};
                imm_zext    <= {16'h0000, f_imm};
                is_rtype    <= c_rtype;
                is_jtype    <= c_jtype;
                is_itype    <= c_itype;
                is_load     <= c_load;
                is_store    <= c_store;
                is_branch   <= c_branch;
                is_jump     <= c_jump;
                reg_write   <= c_reg_write;
                dest_reg    <= c_dest;
            end
        end
    end

endmodule

// File: tb/tb_decoder_32.sv
// tb/tb_decoder_32.sv - self-checking bench for decoder_32
module tb_decoder_32;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] jump_target;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        is_rtype;
    logic        is_jtype;
    logic        is_itype;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        reg_write;
    logic [4:0]  dest_reg;

    decoder_32 dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .out_valid   (out_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .immediate   (immediate),
        .jump_target (jump_target),
        .imm_sext    (imm_sext),
        .imm_zext    (imm_zext),
        .is_rtype    (is_rtype),
        .is_jtype    (is_jtype),
        .is_itype    (is_itype),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .reg_write   (reg_write),
        .dest_reg    (dest_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {rtype, itype, jtype, load, store, branch, jump, reg_write}
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] immediate;
        logic [25:0] jump_target;
        logic [31:0] imm_sext;
        logic [31:0] imm_zext;
        logic [7:0]  flags;
        logic [4:0]  dest_reg;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  flags;
        logic [4:0]  dest;
    } vec_t;

    exp_t act;
    assign act = {opcode, rs, rt, rd, shamt, funct, immediate, jump_target,
                  imm_sext, imm_zext,
                  is_rtype, is_itype, is_jtype, is_load, is_store, is_branch, is_jump, reg_write,
                  dest_reg};

    int errors = 0;
    int checks = 0;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t        e;
        int unsigned op, f_rt, f_rd, fn, imm, dst;
        bit          r, j, ld, st, br, jp, rw;
        op   = w >> 26;
        f_rt = (w >> 16) % 32;
        f_rd = (w >> 11) % 32;
        fn   = w % 64;
        imm  = w % 65536;
        r  = (op == 0);
        j  = (op == 2) || (op == 3);
        ld = op inside {32, 33, 35, 36, 37};
        st = op inside {40, 41, 43};
        br = op inside {1, 4, 5, 6, 7};
        jp = j || (r && (fn == 8 || fn == 9));
        if (r && fn != 8)                            dst = f_rd;
        else if (op == 3)                            dst = 31;
        else if (op == 1 && f_rt inside {16, 17})    dst = 31;
        else if (ld || (op >= 8 && op <= 15))        dst = f_rt;
        else                                         dst = 0;
        rw = (dst != 0);
        e.opcode      = op[5:0];
        e.rs          = 5'((w >> 21) % 32);
        e.rt          = f_rt[4:0];
        e.rd          = f_rd[4:0];
        e.shamt       = 5'((w >> 6) % 32);
        e.funct       = fn[5:0];
        e.immediate   = imm[15:0];
        e.jump_target = 26'(w % (1 << 26));
        e.imm_sext    = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
        e.imm_zext    = imm;
        e.flags       = {r, !r && !j, j, ld, st, br, jp, rw};
        e.dest_reg    = dst[4:0];
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t e, input logic ov);
        checks++;
        if (out_valid !== ov) begin
            errors++;
            $display("FAIL %s out_valid: got %b expected %b", name, out_valid, ov);
        end
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s outputs: got %h expected %h", name, act, e);
        end
    endtask

    // drive at negedge, sample at the following negedge (one rising edge in between)
    task automatic step(input logic r, input logic v, input logic [31:0] w);
        @(negedge clk);
        rst         = r;
        instr_valid = v;
        instruction = w;
        @(negedge clk);
    endtask

    vec_t vecs[15];
    exp_t held;
    exp_t e;
    exp_t ones_exp;

    initial begin
        vecs[0]  = '{32'hFFFF_FFFF, 8'b0100_0000, 5'd0};
        vecs[1]  = '{32'h0129_5020, 8'b1000_0001, 5'd10};
        vecs[2]  = '{32'h016C_402A, 8'b1000_0001, 5'd8};
        vecs[3]  = '{32'h2009_0003, 8'b0100_0001, 5'd9};
        vecs[4]  = '{32'hAE09_0000, 8'b0100_1000, 5'd0};
        vecs[5]  = '{32'h8E0B_0000, 8'b0101_0001, 5'd11};
        vecs[6]  = '{32'h0421_8000, 8'b0100_0100, 5'd0};
        vecs[7]  = '{32'h0421_0000, 8'b0100_0100, 5'd0};
        vecs[8]  = '{32'h0FFF_FFFF, 8'b0010_0011, 5'd31};
        vecs[9]  = '{32'h0A00_0000, 8'b0010_0010, 5'd0};
        vecs[10] = '{32'h03E0_0008, 8'b1000_0010, 5'd0};
        vecs[11] = '{32'h0000_0020, 8'b1000_0000, 5'd0};
        vecs[12] = '{32'h0411_0000, 8'b0100_0101, 5'd31};
        vecs[13] = '{32'h3C00_0005, 8'b0100_0000, 5'd0};
        vecs[14] = '{32'h0120_F809, 8'b1000_0011, 5'd31};

        ones_exp = {6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FF_FFFF,
                    32'hFFFF_FFFF, 32'h0000_FFFF, 8'b0100_0000, 5'd0};

        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = 32'h0;
        step(1'b1, 1'b0, 32'h0);
        check_out("reset", '0, 1'b0);

        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        check_out("all_ones", ones_exp, 1'b1);

        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, vecs[i].instr);
            checks++;
            if ({act.flags, act.dest_reg} !== {vecs[i].flags, vecs[i].dest}) begin
                errors++;
                $display("FAIL vec%0d flags/dest: got %b/%0d expected %b/%0d", i,
                         act.flags, act.dest_reg, vecs[i].flags, vecs[i].dest);
            end
            check_out($sformatf("vec%0d", i), ref_decode(vecs[i].instr), 1'b1);
        end

        step(1'b0, 1'b1, 32'h0421_8000);
        checks++;
        if ({imm_sext, imm_zext} !== {32'hFFFF_8000, 32'h0000_8000}) begin
            errors++;
            $display("FAIL imm_ext: got %h/%h expected FFFF8000/00008000", imm_sext, imm_zext);
        end

        held = ref_decode(32'h0129_5020);
        step(1'b0, 1'b1, 32'h0129_5020);
        step(1'b0, 1'b0, 32'h0FFF_FFFF);
        check_out("hold1", held, 1'b0);
        step(1'b0, 1'b0, 32'hAE09_0000);
        check_out("hold2", held, 1'b0);

        step(1'b1, 1'b1, 32'h0FFF_FFFF);
        check_out("rst_vs_valid", '0, 1'b0);

        held = '0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            logic        r, v;
            w = $urandom;
            if ($urandom_range(0, 1) == 0)
                w[31:26] = 6'($urandom_range(0, 15));
            else if ($urandom_range(0, 2) == 0)
                w[31:26] = 6'($urandom_range(32, 43));
            if (w[31:26] == 6'h00 && $urandom_range(0, 3) == 0)
                w[5:0] = 6'($urandom_range(8, 9));
            if (w[31:26] == 6'h01 && $urandom_range(0, 1) == 0)
                w[20:16] = 5'($urandom_range(16, 17));
            r = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            step(r, v, w);
            if (r)      e = '0;
            else if (v) e = ref_decode(w);
            else        e = held;
            held = e;
            check_out($sformatf("rand%0d", n), e, !r && v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
